// File: rtl/key_debounce.sv
// key_debounce: two independent active-low button channels, each synchronised and
// filtered by a hold-off FSM into a one-cycle press pulse and a debounced level.
module key_debounce #(
    parameter int CNT_MAX = 999_999,
    parameter int CNT_W   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in_1,
    input  logic       key_in_2,
    output logic       key_1,
    output logic       key_2,
    output logic [1:0] key_lvl
);
    typedef enum logic [1:0] {IDLE, PFILT, DOWN, RFILT} state_t;
    logic [1:0] w_raw;
    logic [1:0] w_pulse;
    assign w_raw = {key_in_2, key_in_1};
    genvar g;
    for (g = 0; g < 2; g++) begin : g_ch
        logic [1:0]       r_sync;
        state_t           r_state;
        state_t           w_state_nx;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nx;
        logic             r_pulse;
        logic             w_pulse_nx;
        logic             w_s;
        logic             w_done;
        // Synchroniser resets to released so a held key after reset counts as a new press
        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_sync <= 2'b11;
            else     r_sync <= {r_sync[0], w_raw[g]};
        end
        assign w_s    = r_sync[1];
        assign w_done = r_cnt == CNT_W'(CNT_MAX);
        always_comb begin
            w_state_nx = r_state;
            w_cnt_nx   = '0;
            w_pulse_nx = 1'b0;
            case (r_state)
                IDLE: if (!w_s) w_state_nx = PFILT;
                PFILT: begin
                    if (w_s) w_state_nx = IDLE;
                    else if (w_done) begin
                        w_state_nx = DOWN;
                        w_pulse_nx = 1'b1;
                    end
                    else w_cnt_nx = r_cnt + 1'b1;
                end
                DOWN: if (w_s) w_state_nx = RFILT;
                RFILT: begin
                    if (!w_s) w_state_nx = DOWN;
                    else if (w_done) w_state_nx = IDLE;
                    else w_cnt_nx = r_cnt + 1'b1;
                end
                default: w_state_nx = IDLE;
            endcase
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_nx;
                r_cnt   <= w_cnt_nx;
                r_pulse <= w_pulse_nx;
            end
        end
        assign w_pulse[g] = r_pulse;
        assign key_lvl[g] = (r_state == DOWN) || (r_state == RFILT);
    end
    assign key_1 = w_pulse[0];
    assign key_2 = w_pulse[1];
endmodule
